// File: rtl/exc_commit_ctrl_pkg.sv
// Shared CP0 exception definitions for the writeback commit controller.
// exc_type bit positions, wb_exc_flags bit positions, ExcCode values and the
// default exception vector. These values must match the CP0 block's decode.
package exc_commit_ctrl_pkg;

    localparam int unsigned ADDR_W      = 32;
    localparam int unsigned EXC_TYPE_W  = 7;
    localparam int unsigned EXC_FLAGS_W = 6;
    localparam int unsigned EXCCODE_W   = 5;

    // One-hot exc_type positions: {int, adel, ades, sys, bp, ri, ov}
    localparam int unsigned EXC_OV   = 0;
    localparam int unsigned EXC_RI   = 1;
    localparam int unsigned EXC_BP   = 2;
    localparam int unsigned EXC_SYS  = 3;
    localparam int unsigned EXC_ADES = 4;
    localparam int unsigned EXC_ADEL = 5;
    localparam int unsigned EXC_INT  = 6;

    // wb_exc_flags positions: {adel_if, ri, ov, sys, bp, adel_d}
    localparam int unsigned FLG_ADEL_D  = 0;
    localparam int unsigned FLG_BP      = 1;
    localparam int unsigned FLG_SYS     = 2;
    localparam int unsigned FLG_OV      = 3;
    localparam int unsigned FLG_RI      = 4;
    localparam int unsigned FLG_ADEL_IF = 5;

    // Cause.ExcCode values
    localparam logic [EXCCODE_W-1:0] EXCCODE_INT  = 5'h00;
    localparam logic [EXCCODE_W-1:0] EXCCODE_ADEL = 5'h04;
    localparam logic [EXCCODE_W-1:0] EXCCODE_ADES = 5'h05;
    localparam logic [EXCCODE_W-1:0] EXCCODE_SYS  = 5'h08;
    localparam logic [EXCCODE_W-1:0] EXCCODE_BP   = 5'h09;
    localparam logic [EXCCODE_W-1:0] EXCCODE_RI   = 5'h0A;
    localparam logic [EXCCODE_W-1:0] EXCCODE_OV   = 5'h0C;

    // Exception entry with BEV=1
    localparam logic [ADDR_W-1:0] EXC_VECTOR_DEFAULT = 32'hBFC00380;

    // Source for BadVAddr
    typedef enum logic [1:0] {
        BVA_NONE,
        BVA_PC,
        BVA_MEM
    } bva_sel_e;

    typedef enum logic {
        ST_IDLE,
        ST_REDIR
    } state_e;

    // ExcCode for a one-hot exc_type, as the CP0 block decodes it
    function automatic logic [EXCCODE_W-1:0] exccode_of(input logic [EXC_TYPE_W-1:0] t);
        logic [EXCCODE_W-1:0] code;
        code = EXCCODE_INT;
        if (t[EXC_ADEL]) code = EXCCODE_ADEL;
        if (t[EXC_ADES]) code = EXCCODE_ADES;
        if (t[EXC_SYS])  code = EXCCODE_SYS;
        if (t[EXC_BP])   code = EXCCODE_BP;
        if (t[EXC_RI])   code = EXCCODE_RI;
        if (t[EXC_OV])   code = EXCCODE_OV;
        return code;
    endfunction

endpackage

// File: rtl/exc_commit_ctrl_prio_arb.sv
// exc_prio_arb: combinational priority encoder from WB exception flags and
// the CP0 interrupt request to a one-hot exc_type plus a BadVAddr source.
// Ports:
//   valid_i      qualified WB instruction
//   int_happen_i interrupt request from CP0 (highest priority)
//   flags_i      {adel_if, ri, ov, sys, bp, adel_d}
//   ades_i       store address error (lowest priority)
//   exc_type_o   one-hot {int, adel, ades, sys, bp, ri, ov}
//   bva_sel_o    BadVAddr source for the winning exception
module exc_prio_arb
    import exc_commit_ctrl_pkg::*;
(
    input  logic                   valid_i,
    input  logic                   int_happen_i,
    input  logic [EXC_FLAGS_W-1:0] flags_i,
    input  logic                   ades_i,
    output logic [EXC_TYPE_W-1:0]  exc_type_o,
    output bva_sel_e               bva_sel_o
);

    // Priority: int, adel_if, ri, ov, sys, bp, adel_d, ades
    always_comb begin
        exc_type_o = '0;
        bva_sel_o  = BVA_NONE;
        if (valid_i) begin
            if (int_happen_i) begin
                exc_type_o[EXC_INT] = 1'b1;
            end else if (flags_i[FLG_ADEL_IF]) begin
                exc_type_o[EXC_ADEL] = 1'b1;
                bva_sel_o            = BVA_PC;
            end else if (flags_i[FLG_RI]) begin
                exc_type_o[EXC_RI] = 1'b1;
            end else if (flags_i[FLG_OV]) begin
                exc_type_o[EXC_OV] = 1'b1;
            end else if (flags_i[FLG_SYS]) begin
                exc_type_o[EXC_SYS] = 1'b1;
            end else if (flags_i[FLG_BP]) begin
                exc_type_o[EXC_BP] = 1'b1;
            end else if (flags_i[FLG_ADEL_D]) begin
                exc_type_o[EXC_ADEL] = 1'b1;
                bva_sel_o            = BVA_MEM;
            end else if (ades_i) begin
                exc_type_o[EXC_ADES] = 1'b1;
                bva_sel_o            = BVA_MEM;
            end
        end
    end

endmodule

// File: rtl/exc_commit_ctrl.sv
// Writeback-stage exception/commit controller. Arbitrates WB exceptions and
// interrupts into CP0 events (combinational, sampled by CP0 on the same edge),
// tracks branch delay slots, and issues a flush plus a held redirect to fetch.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   wb_*                          WB instruction info
//   int_happen, epc               from CP0
//   exc_type/exc_pc/is_slot/
//   bad_vaddr/eret                CP0 event inputs
//   wb_kill                       suppress WB register writes
//   flush                         one-cycle pipeline flush
//   redirect_valid/pc/ready       redirect handshake to fetch
module exc_commit_ctrl
    import exc_commit_ctrl_pkg::*;
#(
    parameter int unsigned     PC_W       = ADDR_W,
    parameter logic [PC_W-1:0] EXC_VECTOR = PC_W'(EXC_VECTOR_DEFAULT)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wb_valid,
    input  logic [PC_W-1:0]        wb_pc,
    input  logic                   wb_is_branch,
    input  logic                   wb_is_eret,
    input  logic [EXC_FLAGS_W-1:0] wb_exc_flags,
    input  logic                   wb_ades,
    input  logic [PC_W-1:0]        wb_mem_addr,
    input  logic                   int_happen,
    input  logic [PC_W-1:0]        epc,
    output logic [EXC_TYPE_W-1:0]  exc_type,
    output logic [PC_W-1:0]        exc_pc,
    output logic                   is_slot,
    output logic [PC_W-1:0]        bad_vaddr,
    output logic                   eret,
    output logic                   wb_kill,
    output logic                   flush,
    output logic                   redirect_valid,
    output logic [PC_W-1:0]        redirect_pc,
    input  logic                   redirect_ready
);

    state_e          state_q;
    logic            slot_q;
    logic            flush_q;
    logic            redirect_valid_q;
    logic [PC_W-1:0] redirect_pc_q;

    logic            commit;
    logic            exc_any;
    bva_sel_e        bva_sel;

    // Only IDLE commits; while redirecting, WB holds wrong-path instructions
    assign commit = wb_valid && !rst && (state_q == ST_IDLE);

    exc_prio_arb u_arb (
        .valid_i      (commit),
        .int_happen_i (int_happen),
        .flags_i      (wb_exc_flags),
        .ades_i       (wb_ades),
        .exc_type_o   (exc_type),
        .bva_sel_o    (bva_sel)
    );

    assign exc_any = |exc_type;
    assign eret    = commit && wb_is_eret && !exc_any;
    assign wb_kill = exc_any;
    assign exc_pc  = wb_pc;
    assign is_slot = slot_q;

    assign flush          = flush_q;
    assign redirect_valid = redirect_valid_q;
    assign redirect_pc    = redirect_pc_q;

    // BadVAddr source mux
    always_comb begin
        bad_vaddr = '0;
        unique case (bva_sel)
            BVA_PC:   bad_vaddr = wb_pc;
            BVA_MEM:  bad_vaddr = wb_mem_addr;
            default:  bad_vaddr = '0;
        endcase
    end

    // Redirect FSM, flush pulse and delay-slot tracking
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q          <= ST_IDLE;
            slot_q           <= 1'b0;
            flush_q          <= 1'b0;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= '0;
        end else begin
            flush_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (exc_any || eret) begin
                        flush_q          <= 1'b1;
                        redirect_valid_q <= 1'b1;
                        redirect_pc_q    <= exc_any ? EXC_VECTOR : epc;
                        state_q          <= ST_REDIR;
                    end
                end
                ST_REDIR: begin
                    if (redirect_ready) begin
                        redirect_valid_q <= 1'b0;
                        state_q          <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase

            // A committed branch marks the next committed instruction as a slot
            if (commit && !exc_any && !eret) begin
                slot_q <= wb_is_branch;
            end else if (exc_any || eret || flush_q) begin
                slot_q <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_exc_commit_ctrl.sv
// Scoreboard bench for exc_commit_ctrl: a driver issues directed and random
// WB traffic and pushes expected CP0 events, flush cycles and redirect targets
// into queues; a monitor pops and compares whenever the DUT presents them.
`timescale 1ns/1ps
module tb_exc_commit_ctrl;

    localparam logic [31:0] VEC = 32'hBFC00380;

    logic        clk = 1'b0;
    logic        rst;
    logic        wb_valid;
    logic [31:0] wb_pc;
    logic        wb_is_branch;
    logic        wb_is_eret;
    logic [5:0]  wb_exc_flags;
    logic        wb_ades;
    logic [31:0] wb_mem_addr;
    logic        int_happen;
    logic [31:0] epc;
    logic [6:0]  exc_type;
    logic [31:0] exc_pc;
    logic        is_slot;
    logic [31:0] bad_vaddr;
    logic        eret;
    logic        wb_kill;
    logic        flush;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        redirect_ready;

    always #5 clk = ~clk;

    exc_commit_ctrl dut (
        .clk            (clk),
        .rst            (rst),
        .wb_valid       (wb_valid),
        .wb_pc          (wb_pc),
        .wb_is_branch   (wb_is_branch),
        .wb_is_eret     (wb_is_eret),
        .wb_exc_flags   (wb_exc_flags),
        .wb_ades        (wb_ades),
        .wb_mem_addr    (wb_mem_addr),
        .int_happen     (int_happen),
        .epc            (epc),
        .exc_type       (exc_type),
        .exc_pc         (exc_pc),
        .is_slot        (is_slot),
        .bad_vaddr      (bad_vaddr),
        .eret           (eret),
        .wb_kill        (wb_kill),
        .flush          (flush),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .redirect_ready (redirect_ready)
    );

    typedef struct packed {
        logic [6:0]  typ;
        logic [31:0] pc;
        logic        slot;
        logic [31:0] bva;
        logic        er;
        logic        kill;
    } ev_t;

    ev_t         evq[$];
    int          fq[$];
    logic [31:0] rq[$];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    bit busy  = 1'b0;
    bit slot  = 1'b0;
    bit fire  = 1'b0;
    bit committed = 1'b0;
    bit mon_on = 1'b0;

    // Exception sources in priority order with their one-hot code and BadVAddr source
    // (0: none, 1: instruction PC, 2: data address)
    logic [6:0] CODE [8] = '{7'b1000000, 7'b0100000, 7'b0000010, 7'b0000001,
                             7'b0001000, 7'b0000100, 7'b0100000, 7'b0010000};
    int         SRC  [8] = '{0, 1, 0, 0, 0, 0, 2, 2};

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", nm, got, exp);
        end
    endtask

    // Predict what this cycle's WB contents commit to
    task automatic model_eval();
        ev_t  e;
        logic h [8];
        committed = !rst && wb_valid && !busy;
        fire      = 1'b0;
        if (committed) begin
            h[0] = int_happen;      h[1] = wb_exc_flags[5];
            h[2] = wb_exc_flags[4]; h[3] = wb_exc_flags[3];
            h[4] = wb_exc_flags[2]; h[5] = wb_exc_flags[1];
            h[6] = wb_exc_flags[0]; h[7] = wb_ades;
            e.typ = '0;
            e.bva = '0;
            for (int i = 0; i < 8; i++) begin
                if (h[i] && e.typ == 7'd0) begin
                    e.typ = CODE[i];
                    e.bva = (SRC[i] == 1) ? wb_pc : (SRC[i] == 2) ? wb_mem_addr : 32'd0;
                end
            end
            e.er   = (e.typ == 7'd0) && wb_is_eret;
            e.kill = (e.typ != 7'd0);
            e.pc   = wb_pc;
            e.slot = slot;
            if (e.kill || e.er) begin
                evq.push_back(e);
                fq.push_back(cyc + 1);
                rq.push_back(e.kill ? VEC : epc);
                fire = 1'b1;
            end
        end
    endtask

    // Advance the model across a clock edge using the inputs of the ended cycle
    task automatic model_update();
        if (rst) begin
            busy = 1'b0;
            slot = 1'b0;
            rq.delete();
        end else if (busy && redirect_ready) begin
            busy = 1'b0;
        end else if (fire) begin
            busy = 1'b1;
            slot = 1'b0;
        end else if (committed) begin
            slot = wb_is_branch;
        end
    endtask

    task automatic step();
        model_eval();
        @(posedge clk);
        model_update();
        cyc++;
        #1;
    endtask

    task automatic idle_in();
        rst = 1'b0; wb_valid = 1'b0; wb_pc = '0; wb_is_branch = 1'b0;
        wb_is_eret = 1'b0; wb_exc_flags = '0; wb_ades = 1'b0; wb_mem_addr = '0;
        int_happen = 1'b0; epc = '0; redirect_ready = 1'b0;
    endtask

    task automatic instr(input logic [31:0] pc, input logic br, input logic er,
                         input logic [5:0] fl, input logic ad, input logic [31:0] addr,
                         input logic intr, input logic [31:0] ep);
        idle_in();
        wb_valid = 1'b1; wb_pc = pc; wb_is_branch = br; wb_is_eret = er;
        wb_exc_flags = fl; wb_ades = ad; wb_mem_addr = addr; int_happen = intr; epc = ep;
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) begin
            idle_in();
            redirect_ready = 1'b1;
            step();
        end
    endtask

    // Monitor: compare whatever the DUT presents against the queued expectations
    initial begin : mon
        ev_t e;
        forever begin
            @(negedge clk);
            if (mon_on) begin
                if (exc_type != 7'd0 || eret) begin
                    total++;
                    if (evq.size() == 0) begin
                        bad++;
                        $display("FAIL spurious_event cyc=%0d exc_type=%b eret=%b", cyc, exc_type, eret);
                    end else begin
                        e = evq.pop_front();
                        if (e.typ !== exc_type || e.pc !== exc_pc || e.slot !== is_slot ||
                            e.bva !== bad_vaddr || e.er !== eret || e.kill !== wb_kill) begin
                            bad++;
                            $display("FAIL cp0_event cyc=%0d got type=%b pc=%h slot=%b bva=%h eret=%b kill=%b exp type=%b pc=%h slot=%b bva=%h eret=%b kill=%b",
                                     cyc, exc_type, exc_pc, is_slot, bad_vaddr, eret, wb_kill,
                                     e.typ, e.pc, e.slot, e.bva, e.er, e.kill);
                        end
                    end
                end
                if (flush) begin
                    total++;
                    if (fq.size() == 0) begin
                        bad++;
                        $display("FAIL spurious_flush cyc=%0d", cyc);
                    end else if (fq[0] != cyc) begin
                        bad++;
                        $display("FAIL flush_cycle got=%0d exp=%0d", cyc, fq[0]);
                        void'(fq.pop_front());
                    end else begin
                        void'(fq.pop_front());
                    end
                end
                total++;
                if (redirect_valid !== busy) begin
                    bad++;
                    $display("FAIL redirect_valid cyc=%0d got=%b exp=%b", cyc, redirect_valid, busy);
                end
                if (redirect_valid === 1'b1 && rq.size() > 0) begin
                    total++;
                    if (redirect_pc !== rq[0]) begin
                        bad++;
                        $display("FAIL redirect_pc cyc=%0d got=%h exp=%h", cyc, redirect_pc, rq[0]);
                    end
                    if (redirect_ready && !rst) void'(rq.pop_front());
                end
            end
        end
    end

    initial begin : drv
        idle_in();
        rst = 1'b1;
        // Reset gates CP0 events even with an interrupt and every flag raised
        wb_valid = 1'b1; int_happen = 1'b1; wb_exc_flags = 6'h3F; wb_is_eret = 1'b1;
        step();
        step();
        chk("rst_exc_type", 32'(exc_type), 32'd0);
        chk("rst_eret", 32'(eret), 32'd0);
        chk("rst_wb_kill", 32'(wb_kill), 32'd0);
        chk("rst_redirect_valid", 32'(redirect_valid), 32'd0);
        chk("rst_redirect_pc", redirect_pc, 32'd0);
        chk("rst_flush", 32'(flush), 32'd0);
        chk("rst_is_slot", 32'(is_slot), 32'd0);
        idle_in();
        mon_on = 1'b1;
        step();

        // Overflow, redirect accepted in the third cycle
        instr(32'h80001000, 1'b0, 1'b0, 6'b001000, 1'b0, 32'h0, 1'b0, 32'h0);
        step();
        idle_in(); step();
        idle_in(); redirect_ready = 1'b1; step();
        idle_in(); step();

        // Branch then adel_d in its delay slot
        instr(32'h100, 1'b1, 1'b0, 6'b000000, 1'b0, 32'h0, 1'b0, 32'h0);
        step();
        instr(32'h104, 1'b0, 1'b0, 6'b000001, 1'b0, 32'h1003, 1'b0, 32'h0);
        step();
        drain(2);

        // Interrupt beats sys and eret
        instr(32'h200, 1'b0, 1'b1, 6'b000100, 1'b0, 32'h0, 1'b1, 32'h80002000);
        step();
        drain(2);

        // ERET after a branch: slot cleared, redirect to epc
        instr(32'h300, 1'b1, 1'b0, 6'b000000, 1'b0, 32'h0, 1'b0, 32'h0);
        step();
        instr(32'h304, 1'b0, 1'b1, 6'b000000, 1'b0, 32'h0, 1'b0, 32'h80002000);
        step();
        drain(2);
        instr(32'h400, 1'b0, 1'b0, 6'b000010, 1'b0, 32'h0, 1'b0, 32'h0);
        step();
        drain(2);

        // REDIR stall with wrong-path sys, reset in the third cycle
        instr(32'h500, 1'b0, 1'b0, 6'b000100, 1'b0, 32'h0, 1'b0, 32'h0);
        step();
        for (int i = 0; i < 5; i++) begin
            instr(32'h504 + 32'(4 * i), 1'b0, 1'b0, 6'b000100, 1'b0, 32'h0, 1'b0, 32'h0);
            rst = (i == 2);
            step();
        end
        drain(3);

        // adel_if together with ri at an odd PC
        instr(32'h3, 1'b0, 1'b0, 6'b110000, 1'b0, 32'h55, 1'b0, 32'h0);
        step();
        drain(2);

        // Store address error, lowest priority source
        instr(32'h600, 1'b0, 1'b0, 6'b000000, 1'b1, 32'h2002, 1'b0, 32'h0);
        step();
        drain(2);

        // Random traffic
        for (int n = 0; n < 3000; n++) begin
            idle_in();
            rst            = ($urandom_range(0, 199) == 0);
            wb_valid       = ($urandom_range(0, 9) < 7);
            wb_pc          = $urandom;
            wb_is_branch   = ($urandom_range(0, 3) == 0);
            wb_is_eret     = ($urandom_range(0, 9) == 0);
            for (int b = 0; b < 6; b++) wb_exc_flags[b] = ($urandom_range(0, 15) == 0);
            wb_ades        = ($urandom_range(0, 15) == 0);
            wb_mem_addr    = $urandom;
            int_happen     = ($urandom_range(0, 19) == 0);
            epc            = $urandom;
            redirect_ready = $urandom_range(0, 1) == 1;
            step();
        end
        drain(10);

        chk("events_drained", 32'(evq.size()), 32'd0);
        chk("flushes_drained", 32'(fq.size()), 32'd0);
        chk("redirects_drained", 32'(rq.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
